// File: rtl/ysyx_pkg.sv
// Shared definitions for the multi-cycle core sequencer: FSM states, halt codes, reset PC.
package ysyx_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_MEM_REQ    = 3'd3,
    S_MEM_WAIT   = 3'd4,
    S_WB         = 3'd5,
    S_HALT       = 3'd6
  } state_e;

  localparam logic [2:0] HALT_EBREAK  = 3'd0;
  localparam logic [2:0] HALT_IFETCH  = 3'd1;
  localparam logic [2:0] HALT_LSU     = 3'd2;
  localparam logic [2:0] HALT_ILLEGAL = 3'd3;
  localparam logic [2:0] HALT_WDOG    = 3'd4;

  // States that wait on an external handshake and are guarded by the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH_REQ) || (s == S_FETCH_WAIT) ||
           (s == S_MEM_REQ)   || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_watchdog.sv
// Saturating wait-cycle counter; flags a handshake that has stalled for 2**WD_W-1 cycles.
module ysyx_watchdog #(
  parameter int unsigned WD_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam logic [WD_W-1:0] CNT_MAX = {WD_W{1'b1}};

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // Clear on state change, otherwise count cycles spent waiting and hold at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/ysyx_core_sequencer.sv
// Multi-cycle control FSM: fetch -> execute -> memory -> writeback, with PC/IR, counters and halt logic.
module ysyx_core_sequencer
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned WD_W     = 8,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [31:0]      ifu_req_addr,
  input  logic             ifu_resp_valid,
  output logic             ifu_resp_ready,
  input  logic [31:0]      ifu_resp_inst,
  input  logic             ifu_resp_err,
  input  logic             dec_rf_wr_en,
  input  logic             dec_is_mem,
  input  logic             dec_is_jump,
  input  logic             dec_is_ebreak,
  input  logic             dec_illegal,
  input  logic [31:0]      exu_jump_addr,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  input  logic             lsu_resp_err,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic             rf_wr_en,
  output logic             is_ebreak,
  output logic             halted,
  output logic [2:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      next_pc_q, next_pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [2:0]       halt_code_q, halt_code_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             ifu_req_valid_q, ifu_req_valid_d;
  logic             ifu_resp_ready_q, ifu_resp_ready_d;
  logic             lsu_req_valid_q, lsu_req_valid_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic             is_ebreak_q, is_ebreak_d;
  logic             halted_q, halted_d;
  logic             retire;
  logic             wd_en;
  logic             wd_clear;
  logic             wd_expired;

  assign wd_en    = is_wait_state(state_q);
  assign wd_clear = (state_d != state_q);

  ysyx_watchdog #(
    .WD_W (WD_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .en        (wd_en),
    .expired_c (wd_expired)
  );

  // Next-state, datapath registers and the registered handshake/strobe outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    next_pc_d   = next_pc_q;
    inst_d      = inst_q;
    halt_code_d = halt_code_q;
    retire      = 1'b0;
    is_ebreak_d = 1'b0;

    case (state_q)
      S_FETCH_REQ: begin
        if (ifu_req_ready) begin
          state_d = S_FETCH_WAIT;
        end else if (wd_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_WDOG;
        end
      end
      S_FETCH_WAIT: begin
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            state_d     = S_HALT;
            halt_code_d = HALT_IFETCH;
          end else begin
            inst_d  = ifu_resp_inst;
            state_d = S_EXEC;
          end
        end else if (wd_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_WDOG;
        end
      end
      S_EXEC: begin
        next_pc_d = dec_is_jump ? exu_jump_addr : (pc_q + 32'd4);
        if (dec_illegal) begin
          state_d     = S_HALT;
          halt_code_d = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = HALT_EBREAK;
          is_ebreak_d = 1'b1;
          retire      = 1'b1;
        end else if (dec_is_mem) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        if (lsu_req_ready) begin
          state_d = S_MEM_WAIT;
        end else if (wd_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_WDOG;
        end
      end
      S_MEM_WAIT: begin
        if (lsu_resp_valid) begin
          if (lsu_resp_err) begin
            state_d     = S_HALT;
            halt_code_d = HALT_LSU;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired) begin
          state_d     = S_HALT;
          halt_code_d = HALT_WDOG;
        end
      end
      S_WB: begin
        pc_d    = next_pc_q;
        retire  = 1'b1;
        state_d = S_FETCH_REQ;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Outputs follow the state being entered so they are valid for the whole state.
    ifu_req_valid_d  = (state_d == S_FETCH_REQ);
    ifu_resp_ready_d = (state_d == S_FETCH_WAIT);
    lsu_req_valid_d  = (state_d == S_MEM_REQ);
    rf_wr_en_d       = (state_d == S_WB) && dec_rf_wr_en;
    halted_d         = (state_d == S_HALT);

    cycle_d   = cycle_q + CNT_W'(state_q != S_HALT);
    instret_d = instret_q + CNT_W'(retire);
  end

  // State and output registers; the reset state is FETCH_REQ, whose request is already asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_FETCH_REQ;
      pc_q             <= RESET_PC;
      next_pc_q        <= RESET_PC;
      inst_q           <= '0;
      halt_code_q      <= '0;
      cycle_q          <= '0;
      instret_q        <= '0;
      ifu_req_valid_q  <= 1'b1;
      ifu_resp_ready_q <= 1'b0;
      lsu_req_valid_q  <= 1'b0;
      rf_wr_en_q       <= 1'b0;
      is_ebreak_q      <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      next_pc_q        <= next_pc_d;
      inst_q           <= inst_d;
      halt_code_q      <= halt_code_d;
      cycle_q          <= cycle_d;
      instret_q        <= instret_d;
      ifu_req_valid_q  <= ifu_req_valid_d;
      ifu_resp_ready_q <= ifu_resp_ready_d;
      lsu_req_valid_q  <= lsu_req_valid_d;
      rf_wr_en_q       <= rf_wr_en_d;
      is_ebreak_q      <= is_ebreak_d;
      halted_q         <= halted_d;
    end
  end

  assign ifu_req_valid  = ifu_req_valid_q;
  assign ifu_req_addr   = pc_q;
  assign ifu_resp_ready = ifu_resp_ready_q;
  assign lsu_req_valid  = lsu_req_valid_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign rf_wr_en       = rf_wr_en_q;
  assign is_ebreak      = is_ebreak_q;
  assign halted         = halted_q;
  assign halt_code      = halt_code_q;
  assign cycle_cnt      = cycle_q;
  assign instret_cnt    = instret_q;

endmodule

// File: tb/tb_ysyx_core_sequencer.sv
// Scoreboard bench for ysyx_core_sequencer: directed programs, zero-wait memory model, retire/halt monitor.
module tb_ysyx_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_JAL  = 32'h1000_006f;
  localparam logic [31:0] I_LW   = 32'h0000_2103;
  localparam logic [31:0] I_SW   = 32'h0020_2023;
  localparam logic [31:0] I_EBRK = 32'h0010_0073;
  localparam logic [31:0] I_ILL  = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_inst;
  logic        ifu_resp_err;
  logic        dec_rf_wr_en, dec_is_mem, dec_is_jump, dec_is_ebreak, dec_illegal;
  logic [31:0] exu_jump_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic [31:0] inst, pc;
  logic        rf_wr_en, is_ebreak, halted;
  logic [2:0]  halt_code;
  logic [63:0] cycle_cnt, instret_cnt;

  logic [31:0] mem [0:255];
  logic [31:0] hi_inst;

  ysyx_core_sequencer #(
    .RESET_PC (32'h8000_0000),
    .WD_W     (4),
    .CNT_W    (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_inst  (ifu_resp_inst),
    .ifu_resp_err   (ifu_resp_err),
    .dec_rf_wr_en   (dec_rf_wr_en),
    .dec_is_mem     (dec_is_mem),
    .dec_is_jump    (dec_is_jump),
    .dec_is_ebreak  (dec_is_ebreak),
    .dec_illegal    (dec_illegal),
    .exu_jump_addr  (exu_jump_addr),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_err   (lsu_resp_err),
    .inst           (inst),
    .pc             (pc),
    .rf_wr_en       (rf_wr_en),
    .is_ebreak      (is_ebreak),
    .halted         (halted),
    .halt_code      (halt_code),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  always #5 clk = ~clk;

  // Minimal IDU stand-in decoding the instruction register.
  always_comb begin
    dec_rf_wr_en  = 1'b0;
    dec_is_mem    = 1'b0;
    dec_is_jump   = 1'b0;
    dec_is_ebreak = 1'b0;
    dec_illegal   = 1'b0;
    case (inst[6:0])
      7'h13: dec_rf_wr_en = 1'b1;
      7'h6f: begin dec_rf_wr_en = 1'b1; dec_is_jump = 1'b1; end
      7'h03: begin dec_rf_wr_en = 1'b1; dec_is_mem = 1'b1; end
      7'h23: dec_is_mem = 1'b1;
      7'h73: if (inst == I_EBRK) dec_is_ebreak = 1'b1; else dec_illegal = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (a[31:10] == 22'h20_0000) return mem[a[9:2]];
    else if (a == 32'hFFFF_FFFC) return hi_inst;
    else return I_EBRK;
  endfunction

  // Instruction memory: data for the current fetch address, ready well before the next edge.
  always @(negedge clk) ifu_resp_inst = lookup(ifu_req_addr);

  typedef struct {
    bit          is_halt;
    logic [31:0] pc;
    logic [63:0] instret;
    logic [63:0] cyc;
    logic [63:0] rf;
    logic [63:0] eb;
    logic [2:0]  code;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] prev_instret;
  bit          prev_halted;
  int          rf_cnt, eb_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_ret(input logic [31:0] p, input logic [63:0] ir, input logic [63:0] cy,
                          input logic [63:0] rf);
    exp_t x;
    x.is_halt = 1'b0; x.pc = p; x.instret = ir; x.cyc = cy; x.rf = rf; x.eb = '0; x.code = '0;
    exp_q.push_back(x);
  endtask

  task automatic push_halt(input logic [2:0] code, input logic [31:0] p, input logic [63:0] ir,
                           input logic [63:0] cy, input logic [63:0] eb);
    exp_t x;
    x.is_halt = 1'b1; x.pc = p; x.instret = ir; x.cyc = cy; x.rf = '0; x.eb = eb; x.code = code;
    exp_q.push_back(x);
  endtask

  // Monitor: every retire (instret change) and halt entry pops and checks one expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_instret = '0;
      prev_halted  = 1'b0;
      rf_cnt       = 0;
      eb_cnt       = 0;
    end else begin
      if (rf_wr_en)  rf_cnt++;
      if (is_ebreak) eb_cnt++;
      if (instret_cnt != prev_instret) begin
        prev_instret = instret_cnt;
        if (exp_q.size() == 0 || exp_q[0].is_halt) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_retire: got instret %0d at pc 0x%h, expected no retire",
                   instret_cnt, pc);
        end else begin
          e = exp_q.pop_front();
          chk("ret_instret",    instret_cnt,        e.instret);
          chk("ret_pc",         64'(pc),            64'(e.pc));
          chk("ret_fetch_addr", 64'(ifu_req_addr),  64'(e.pc));
          chk("ret_rf_pulses",  64'(rf_cnt),        e.rf);
          chk("ret_cycle",      cycle_cnt,          e.cyc);
        end
        rf_cnt = 0;
      end
      if (halted && !prev_halted) begin
        prev_halted = 1'b1;
        if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_halt: got halt code %0d at pc 0x%h, expected no halt",
                   halt_code, pc);
        end else begin
          e = exp_q.pop_front();
          chk("halt_code",      64'(halt_code), 64'(e.code));
          chk("halt_pc",        64'(pc),        64'(e.pc));
          chk("halt_instret",   instret_cnt,    e.instret);
          chk("halt_cycle",     cycle_cnt,      e.cyc);
          chk("halt_ebreak",    64'(eb_cnt),    e.eb);
          chk("halt_rf_pulses", 64'(rf_cnt),    64'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_env();
    ifu_req_ready  = 1'b1;
    ifu_resp_valid = 1'b1;
    ifu_resp_err   = 1'b0;
    lsu_req_ready  = 1'b1;
    lsu_resp_valid = 1'b1;
    lsu_resp_err   = 1'b0;
    exu_jump_addr  = 32'h0;
    hi_inst        = I_EBRK;
    for (int i = 0; i < 256; i++) mem[i] = I_EBRK;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic check_frozen(input string name, input logic [63:0] cy, input logic [63:0] eb);
    tick(); tick(); tick();
    chk({name, "_cycle_frozen"}, cycle_cnt, cy);
    chk({name, "_ebreak_total"}, 64'(eb_cnt), eb);
    chk({name, "_halted"}, 64'(halted), 64'(1));
    chk({name, "_no_req"}, 64'(ifu_req_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_env();
    reset_dut();
    chk("rst_pc",          64'(pc),             64'(RST_PC));
    chk("rst_inst",        64'(inst),           64'(0));
    chk("rst_cycle",       cycle_cnt,           64'(0));
    chk("rst_instret",     instret_cnt,         64'(0));
    chk("rst_halted",      64'(halted),         64'(0));
    chk("rst_halt_code",   64'(halt_code),      64'(0));
    chk("rst_rf_wr_en",    64'(rf_wr_en),       64'(0));
    chk("rst_is_ebreak",   64'(is_ebreak),      64'(0));
    chk("rst_lsu_req",     64'(lsu_req_valid),  64'(0));
    chk("rst_resp_ready",  64'(ifu_resp_ready), 64'(0));

    // addi then ebreak
    set_env(); reset_dut();
    mem[0] = I_ADDI;
    push_ret(32'h8000_0004, 1, 4, 1);
    push_ret(32'h8000_0004, 2, 7, 0);
    push_halt(3'd0, 32'h8000_0004, 2, 7, 1);
    rst = 1'b0;
    drain("addi", 60);
    check_frozen("addi", 7, 1);

    // jal -> addi at target -> ebreak
    set_env(); reset_dut();
    mem[0] = I_JAL; mem[8'h40] = I_ADDI; exu_jump_addr = 32'h8000_0100;
    push_ret(32'h8000_0100, 1, 4, 1);
    push_ret(32'h8000_0104, 2, 8, 1);
    push_ret(32'h8000_0104, 3, 11, 0);
    push_halt(3'd0, 32'h8000_0104, 3, 11, 1);
    rst = 1'b0;
    drain("jal", 60);

    // fetch request stalled 5 cycles
    set_env(); ifu_req_ready = 1'b0; reset_dut();
    mem[0] = I_ADDI;
    push_ret(32'h8000_0004, 1, 9, 1);
    push_ret(32'h8000_0004, 2, 12, 0);
    push_halt(3'd0, 32'h8000_0004, 2, 12, 1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid",  64'(ifu_req_valid),  64'(1));
      chk("stall_req_addr",   64'(ifu_req_addr),   64'(RST_PC));
      chk("stall_resp_ready", 64'(ifu_resp_ready), 64'(0));
    end
    ifu_req_ready = 1'b1;
    drain("stall", 60);

    // load with access fault
    set_env(); lsu_resp_err = 1'b1; reset_dut();
    mem[0] = I_LW;
    push_halt(3'd2, RST_PC, 0, 5, 0);
    rst = 1'b0;
    drain("lsu_err", 60);
    check_frozen("lsu_err", 5, 0);

    // load, store, ebreak
    set_env(); reset_dut();
    mem[0] = I_LW; mem[1] = I_SW;
    push_ret(32'h8000_0004, 1, 6, 1);
    push_ret(32'h8000_0008, 2, 12, 0);
    push_ret(32'h8000_0008, 3, 15, 0);
    push_halt(3'd0, 32'h8000_0008, 3, 15, 1);
    rst = 1'b0;
    drain("ldst", 60);

    // illegal encoding
    set_env(); reset_dut();
    mem[0] = I_ILL;
    push_halt(3'd3, RST_PC, 0, 3, 0);
    rst = 1'b0;
    drain("illegal", 60);

    // instruction fetch fault
    set_env(); ifu_resp_err = 1'b1; reset_dut();
    mem[0] = I_ADDI;
    push_halt(3'd1, RST_PC, 0, 2, 0);
    rst = 1'b0;
    drain("ifetch_err", 60);

    // fetch response never arrives: watchdog (WD_W=4)
    set_env(); ifu_resp_valid = 1'b0; reset_dut();
    push_halt(3'd4, RST_PC, 0, 17, 0);
    rst = 1'b0;
    drain("wdog", 60);
    check_frozen("wdog", 17, 0);

    // reset while waiting on a load response
    set_env(); lsu_resp_valid = 1'b0; reset_dut();
    mem[0] = I_ADDI; mem[1] = I_LW;
    push_ret(32'h8000_0004, 1, 4, 1);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    drain("mw", 0);
    chk("mw_pc",        64'(pc),            64'(32'h8000_0004));
    chk("mw_lsu_req",   64'(lsu_req_valid), 64'(0));
    chk("mw_halted",    64'(halted),        64'(0));
    chk("mw_instret",   instret_cnt,        64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mwrst_pc",        64'(pc),            64'(RST_PC));
    chk("mwrst_req_valid", 64'(ifu_req_valid), 64'(1));
    chk("mwrst_lsu_req",   64'(lsu_req_valid), 64'(0));
    chk("mwrst_instret",   instret_cnt,        64'(0));
    chk("mwrst_cycle",     cycle_cnt,          64'(0));

    // pc+4 wraps at 2**32
    set_env(); reset_dut();
    mem[0] = I_JAL; exu_jump_addr = 32'hFFFF_FFFC; hi_inst = I_ADDI;
    push_ret(32'hFFFF_FFFC, 1, 4, 1);
    push_ret(32'h0000_0000, 2, 8, 1);
    push_ret(32'h0000_0000, 3, 11, 0);
    push_halt(3'd0, 32'h0000_0000, 3, 11, 1);
    rst = 1'b0;
    drain("wrap", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
